// File: rtl/instr_encoder_if.sv
// Stream bundle between an RV32I field producer and the instruction encoder.
// Producer side is the master; the encoder is the slave.
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into a 32-bit word, replacing unencodable input with
// a NOP, and streams the result through one registered stage with a byte address.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  instr_encoder_if.slave   bus,
  output logic [CNT_W-1:0] err_count
);
  localparam logic [6:0]  OP_R      = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic              r_valid;
  logic [31:0]       r_instr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [CNT_W-1:0]  r_err_cnt;

  logic        w_accept;
  logic        w_deliver;
  logic [31:0] w_raw;
  logic [31:0] w_instr;
  logic        w_err;
  logic        w_fit12;
  logic        w_fit13;
  logic        w_fit21;

  logic [31:0] w_imm;
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  assign w_imm = bus.in_imm;
  assign w_op  = bus.in_opcode;
  assign w_f3  = bus.in_funct3;

  // Signed range checks: every bit above the top encodable bit must match it.
  assign w_fit12 = (&w_imm[31:11]) | ~(|w_imm[31:11]);
  assign w_fit13 = (&w_imm[31:12]) | ~(|w_imm[31:12]);
  assign w_fit21 = (&w_imm[31:20]) | ~(|w_imm[31:20]);

  always_comb begin
    w_raw = NOP;
    w_err = 1'b0;
    case (w_op)
      OP_R: begin
        w_raw = {bus.in_funct7, bus.in_rs2, bus.in_rs1, w_f3, bus.in_rd, w_op};
      end
      OP_IMM: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          w_raw = {bus.in_funct7, w_imm[4:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
          w_err = |w_imm[31:5];
        end else begin
          w_raw = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
          w_err = ~w_fit12;
        end
      end
      OP_LOAD, OP_JALR: begin
        w_raw = {w_imm[11:0], bus.in_rs1, w_f3, bus.in_rd, w_op};
        w_err = ~w_fit12;
      end
      OP_STORE: begin
        w_raw = {w_imm[11:5], bus.in_rs2, bus.in_rs1, w_f3, w_imm[4:0], w_op};
        w_err = ~w_fit12;
      end
      OP_BRANCH: begin
        w_raw = {w_imm[12], w_imm[10:5], bus.in_rs2, bus.in_rs1, w_f3,
                 w_imm[4:1], w_imm[11], w_op};
        w_err = ~w_fit13 | w_imm[0];
      end
      OP_LUI, OP_AUIPC: begin
        w_raw = {w_imm[31:12], bus.in_rd, w_op};
        w_err = |w_imm[11:0];
      end
      OP_JAL: begin
        w_raw = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], bus.in_rd, w_op};
        w_err = ~w_fit21 | w_imm[0];
      end
      default: begin
        w_raw = NOP;
        w_err = 1'b1;
      end
    endcase
  end

  assign w_instr = w_err ? NOP : w_raw;

  assign bus.in_ready = ~r_valid | bus.out_ready;
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_deliver    = r_valid & bus.out_ready;

  // r_addr always names the held word; it moves on only when that word leaves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_err     <= 1'b0;
      r_addr    <= BASE_ADDR;
      r_err_cnt <= '0;
    end else begin
      if (w_deliver) begin
        r_addr <= r_addr + ADDR_W'(4);
        if (r_err && !(&r_err_cnt))
          r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
        r_err   <= w_err;
      end else if (w_deliver) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_instr = r_instr;
  assign bus.out_addr  = r_addr;
  assign bus.out_err   = r_err;
  assign err_count     = r_err_cnt;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of hand-encoded vectors streamed
// back-to-back, plus backpressure, mid-stream reset and a narrow-width instance.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(32)) ifm ();
  instr_encoder_if #(.ADDR_W(4))  ifs ();
  logic [7:0] cnt_m;
  logic [1:0] cnt_s;

  instr_encoder #(.ADDR_W(32), .BASE_ADDR(32'h0), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .bus(ifm.slave), .err_count(cnt_m));
  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'hC), .CNT_W(2)) u_small (
    .clk(clk), .rst(rst), .bus(ifs.slave), .err_count(cnt_s));

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic vec_t mk(string nm, logic [6:0] op, logic [4:0] rd, logic [4:0] rs1,
                              logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                              logic [31:0] imm, logic [31:0] exp, logic err);
    vec_t v;
    v.name = nm; v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_m(input vec_t v);
    ifm.in_opcode = v.op; ifm.in_rd = v.rd; ifm.in_rs1 = v.rs1; ifm.in_rs2 = v.rs2;
    ifm.in_funct3 = v.f3; ifm.in_funct7 = v.f7; ifm.in_imm = v.imm;
    ifm.in_valid = 1'b1;
  endtask

  logic [31:0] exp_addr;
  int          exp_errs;

  initial begin
    ifm.in_valid = 0; ifm.out_ready = 1; ifm.in_opcode = 0; ifm.in_rd = 0; ifm.in_rs1 = 0;
    ifm.in_rs2 = 0; ifm.in_funct3 = 0; ifm.in_funct7 = 0; ifm.in_imm = 0;
    ifs.in_valid = 0; ifs.out_ready = 1; ifs.in_opcode = 7'h7F; ifs.in_rd = 0; ifs.in_rs1 = 0;
    ifs.in_rs2 = 0; ifs.in_funct3 = 0; ifs.in_funct7 = 0; ifs.in_imm = 0;

    //            name      op          rd rs1 rs2 f3      f7           imm            expected      err
    vecs.push_back(mk("add",   7'b0110011, 5, 1, 2, 3'b000, 7'b0000000, 32'd0,         32'h002082B3, 0));
    vecs.push_back(mk("addi",  7'b0010011, 5, 1, 0, 3'b000, 7'b0000000, 32'hFFFFFFFF,  32'hFFF08293, 0));
    vecs.push_back(mk("sw",    7'b0100011, 0, 1, 2, 3'b010, 7'b0000000, 32'hFFFFFFFC,  32'hFE20AE23, 0));
    vecs.push_back(mk("beq",   7'b1100011, 0, 1, 2, 3'b000, 7'b0000000, 32'hFFFFFFF8,  32'hFE208CE3, 0));
    vecs.push_back(mk("jal",   7'b1101111, 5, 0, 0, 3'b000, 7'b0000000, 32'hFFFFFFFC,  32'hFFDFF2EF, 0));
    vecs.push_back(mk("lui",   7'b0110111, 3, 0, 0, 3'b000, 7'b0000000, 32'h12345000,  32'h123451B7, 0));
    vecs.push_back(mk("slli",  7'b0010011, 1, 2, 0, 3'b001, 7'b0000000, 32'd3,         32'h00311093, 0));
    vecs.push_back(mk("srai",  7'b0010011, 1, 2, 0, 3'b101, 7'b0100000, 32'd3,         32'h40315093, 0));
    vecs.push_back(mk("addi_min", 7'b0010011, 5, 1, 0, 3'b000, 7'b0, 32'hFFFFF800,     32'h80008293, 0));
    vecs.push_back(mk("addi_max", 7'b0010011, 5, 1, 0, 3'b000, 7'b0, 32'd2047,         32'h7FF08293, 0));
    vecs.push_back(mk("beq_odd",  7'b1100011, 0, 1, 2, 3'b000, 7'b0, 32'd3,            32'h00000013, 1));
    vecs.push_back(mk("addi_2048",7'b0010011, 5, 1, 0, 3'b000, 7'b0, 32'd2048,         32'h00000013, 1));
    vecs.push_back(mk("bad_op",   7'b1111111, 5, 1, 2, 3'b000, 7'b0, 32'd0,            32'h00000013, 1));
    vecs.push_back(mk("addi_m2049",7'b0010011,5, 1, 0, 3'b000, 7'b0, 32'hFFFFF7FF,     32'h00000013, 1));
    vecs.push_back(mk("slli_32",  7'b0010011, 1, 2, 0, 3'b001, 7'b0, 32'd32,           32'h00000013, 1));
    vecs.push_back(mk("lui_low",  7'b0110111, 3, 0, 0, 3'b000, 7'b0, 32'h00001001,     32'h00000013, 1));
    vecs.push_back(mk("jal_odd",  7'b1101111, 5, 0, 0, 3'b000, 7'b0, 32'd1,            32'h00000013, 1));

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_valid",   {31'd0, ifm.out_valid}, 32'd0);
    chk("rst_instr",   ifm.out_instr, 32'd0);
    chk("rst_err",     {31'd0, ifm.out_err}, 32'd0);
    chk("rst_addr",    ifm.out_addr, 32'd0);
    chk("rst_cnt",     {24'd0, cnt_m}, 32'd0);
    chk("rst_ready",   {31'd0, ifm.in_ready}, 32'd1);
    chk("rst_addr_s",  {28'd0, ifs.out_addr}, 32'hC);

    // Full-throughput stream of the table
    exp_addr = 32'd0;
    exp_errs = 0;
    apply_m(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk({vecs[i].name, "_valid"}, {31'd0, ifm.out_valid}, 32'd1);
      chk({vecs[i].name, "_instr"}, ifm.out_instr, vecs[i].exp);
      chk({vecs[i].name, "_err"},   {31'd0, ifm.out_err}, {31'd0, vecs[i].err});
      chk({vecs[i].name, "_addr"},  ifm.out_addr, exp_addr);
      chk({vecs[i].name, "_ready"}, {31'd0, ifm.in_ready}, 32'd1);
      chk({vecs[i].name, "_cnt"},   {24'd0, cnt_m}, exp_errs);
      exp_addr += 4;
      if (vecs[i].err) exp_errs++;
      if (i + 1 < vecs.size()) apply_m(vecs[i+1]);
      else ifm.in_valid = 1'b0;
    end
    @(negedge clk);
    chk("stream_drained", {31'd0, ifm.out_valid}, 32'd0);
    chk("stream_cnt",     {24'd0, cnt_m}, exp_errs);
    chk("stream_addr",    ifm.out_addr, exp_addr);

    // Backpressure: word held for 5 cycles, then delivered once while the next is taken
    ifm.out_ready = 1'b0;
    apply_m(vecs[0]);
    @(negedge clk);
    apply_m(vecs[1]);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {31'd0, ifm.out_valid}, 32'd1);
      chk("hold_instr", ifm.out_instr, vecs[0].exp);
      chk("hold_addr",  ifm.out_addr, exp_addr);
      chk("hold_ready", {31'd0, ifm.in_ready}, 32'd0);
      @(negedge clk);
    end
    ifm.out_ready = 1'b1;
    #1;
    chk("release_ready", {31'd0, ifm.in_ready}, 32'd1);
    @(negedge clk);
    ifm.in_valid = 1'b0;
    chk("release_instr", ifm.out_instr, vecs[1].exp);
    chk("release_addr",  ifm.out_addr, exp_addr + 32'd4);
    chk("release_valid", {31'd0, ifm.out_valid}, 32'd1);
    @(negedge clk);
    chk("release_drain", {31'd0, ifm.out_valid}, 32'd0);
    chk("release_addr2", ifm.out_addr, exp_addr + 32'd8);

    // Reset with an errored word still held
    ifm.out_ready = 1'b0;
    apply_m(vecs[12]);
    @(negedge clk);
    ifm.in_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, ifm.out_valid}, 32'd1);
    chk("pre_rst_err",   {31'd0, ifm.out_err}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifm.out_ready = 1'b1;
    chk("midrst_valid", {31'd0, ifm.out_valid}, 32'd0);
    chk("midrst_addr",  ifm.out_addr, 32'd0);
    chk("midrst_cnt",   {24'd0, cnt_m}, 32'd0);
    chk("midrst_err",   {31'd0, ifm.out_err}, 32'd0);
    chk("midrst_instr", ifm.out_instr, 32'd0);
    @(negedge clk);
    chk("midrst_nocount", {24'd0, cnt_m}, 32'd0);

    // Narrow instance: address wrap from C and 2-bit counter saturation
    ifs.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) ifs.in_valid = 1'b0;
      chk("s_valid", {31'd0, ifs.out_valid}, 32'd1);
      chk("s_instr", ifs.out_instr, 32'h00000013);
      chk("s_err",   {31'd0, ifs.out_err}, 32'd1);
      chk("s_addr",  {28'd0, ifs.out_addr}, {28'd0, 4'(4'hC + 4'(4 * k))});
      chk("s_cnt",   {30'd0, cnt_s}, (k < 3) ? k : 3);
    end
    @(negedge clk);
    chk("s_drain", {31'd0, ifs.out_valid}, 32'd0);
    chk("s_sat",   {30'd0, cnt_s}, 32'd3);
    chk("s_addr_end", {28'd0, ifs.out_addr}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
